// File: rtl/prbs_checker_if.sv
// prbs_checker_if: bit stream in, lock status and error counters out
interface prbs_checker_if;
  logic d_in;
  logic d_valid;
  logic clear_counts;
  logic locked;
  logic err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;
  modport master(output d_in, d_valid, clear_counts, input locked, err_pulse, err_count, bit_count);
  modport slave(input d_in, d_valid, clear_counts, output locked, err_pulse, err_count, bit_count);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: PRBS7 (x^7+x^6+1) lock detector and bit error counter
module prbs_checker #(
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_ERRS = 8,
  parameter int WINDOW = 64
) (
  input logic clk_x8,
  input logic rst,
  prbs_checker_if.slave bus
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int WW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state_q;
  logic [6:0] s_q;
  logic [2:0] fill_q;
  logic [RW-1:0] run_q;
  logic [WW-1:0] win_q;
  logic [EW-1:0] werr_q;
  logic err_pulse_q;
  logic [15:0] err_count_q;
  logic [31:0] bit_count_q;
  logic p, miss, match, loss, wrap;
  logic [EW-1:0] werr_d;
  always_comb begin
    p = s_q[6] ^ s_q[5];
    miss = bus.d_in != p;
    match = !miss && s_q != '0;
    werr_d = werr_q + EW'(miss);
    loss = werr_d >= EW'(LOSS_ERRS);
    wrap = win_q == WW'(WINDOW - 1);
  end
  always_ff @(posedge clk_x8) begin
    if (rst) begin
      state_q <= HUNT;
      s_q <= '0;
      fill_q <= '0;
      run_q <= '0;
      win_q <= '0;
      werr_q <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.d_valid) begin
        if (state_q == HUNT) begin
          s_q <= {s_q[5:0], bus.d_in};
          if (fill_q != 3'd7) fill_q <= fill_q + 3'd1;
          else if (!match) run_q <= '0;
          else if (run_q == RW'(LOCK_COUNT - 1)) begin
            state_q <= LOCKED;
            run_q <= '0;
            win_q <= '0;
            werr_q <= '0;
          end else run_q <= run_q + RW'(1);
        end else begin
          s_q <= {s_q[5:0], p};
          err_pulse_q <= miss;
          if (bit_count_q != '1) bit_count_q <= bit_count_q + 32'd1;
          if (miss && err_count_q != '1) err_count_q <= err_count_q + 16'd1;
          if (loss) begin
            state_q <= HUNT;
            fill_q <= '0;
            run_q <= '0;
            win_q <= '0;
            werr_q <= '0;
          end else begin
            win_q <= wrap ? '0 : win_q + WW'(1);
            werr_q <= wrap ? '0 : werr_d;
          end
        end
      end
      if (bus.clear_counts) begin
        err_count_q <= '0;
        bit_count_q <= '0;
      end
    end
  end
  assign bus.locked = state_q == LOCKED;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: segment table, corner sequences and random traffic against a queue-based model
module tb_prbs_checker;
  localparam int LOCK_COUNT = 32;
  localparam int LOSS_ERRS = 8;
  localparam int WINDOW = 64;
  logic clk_x8 = 1'b0;
  logic rst;
  prbs_checker_if bus();
  prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_ERRS(LOSS_ERRS), .WINDOW(WINDOW)) dut (
    .clk_x8(clk_x8),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk_x8 = ~clk_x8;
  int n_checks = 0;
  int n_errs = 0;
  logic [6:0] gen_s = 7'h7F;
  bit ref_q[$];
  int hunt_bits, streak, lock_bits, win_errs;
  bit m_locked, m_pulse;
  longint m_errs, m_bits;
  typedef struct {
    int nbits;
    int nerr;
    int gap;
    bit exp_locked;
    int exp_errs;
    int exp_bits;
  } seg_t;
  seg_t segs[9];
  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic bit gen_next();
    bit b = gen_s[6] ^ gen_s[5];
    gen_s = {gen_s[5:0], b};
    return b;
  endfunction
  task automatic model_reset();
    ref_q.delete();
    repeat (7) ref_q.push_back(1'b0);
    hunt_bits = 0;
    streak = 0;
    lock_bits = 0;
    win_errs = 0;
    m_locked = 0;
    m_pulse = 0;
    m_errs = 0;
    m_bits = 0;
  endtask
  task automatic model_step(bit din, bit dv, bit clr, bit r);
    bit pred;
    bit nz;
    if (r) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    if (dv) begin
      pred = ref_q[0] ^ ref_q[1];
      nz = 0;
      foreach (ref_q[i]) nz |= ref_q[i];
      if (!m_locked) begin
        if (hunt_bits >= 7) streak = (din == pred && nz) ? streak + 1 : 0;
        hunt_bits++;
        ref_q.push_back(din);
        if (streak == LOCK_COUNT) begin
          m_locked = 1;
          lock_bits = 0;
          win_errs = 0;
        end
      end else begin
        ref_q.push_back(pred);
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        lock_bits++;
        if (din != pred) begin
          m_pulse = 1;
          if (m_errs < 64'hFFFF) m_errs++;
          win_errs++;
        end
        if (win_errs >= LOSS_ERRS) begin
          m_locked = 0;
          hunt_bits = 0;
          streak = 0;
        end else if (lock_bits % WINDOW == 0) win_errs = 0;
      end
      void'(ref_q.pop_front());
    end
    if (clr) begin
      m_errs = 0;
      m_bits = 0;
    end
  endtask
  task automatic step(bit din, bit dv, bit clr, bit r);
    bus.d_in = din;
    bus.d_valid = dv;
    bus.clear_counts = clr;
    rst = r;
    @(posedge clk_x8);
    model_step(din, dv, clr, r);
    #1;
    chk("locked", bus.locked, m_locked);
    chk("err_pulse", bus.err_pulse, m_pulse);
    chk("err_count", bus.err_count, m_errs);
    chk("bit_count", bus.bit_count, m_bits);
  endtask
  task automatic send(bit flip, bit clr);
    step(gen_next() ^ flip, 1'b1, clr, 1'b0);
  endtask
  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    gen_s = 7'h7F;
  endtask
  initial begin
    int rate;
    bit r, dv, clr, flip;
    bus.d_in = 1'b0;
    bus.d_valid = 1'b0;
    bus.clear_counts = 1'b0;
    rst = 1'b1;
    model_reset();
    segs[0] = '{38, 0, 1, 1'b0, 0, 0};
    segs[1] = '{1, 0, 1, 1'b1, 0, 0};
    segs[2] = '{10, 1, 1, 1'b1, 1, 10};
    segs[3] = '{54, 0, 1, 1'b1, 1, 64};
    segs[4] = '{64, 7, 8, 1'b1, 8, 128};
    segs[5] = '{64, 7, 8, 1'b1, 15, 192};
    segs[6] = '{8, 8, 1, 1'b0, 23, 200};
    segs[7] = '{38, 0, 1, 1'b0, 23, 200};
    segs[8] = '{1, 0, 1, 1'b1, 23, 200};
    do_reset();
    chk("rst_locked", bus.locked, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_bit_count", bus.bit_count, 0);
    foreach (segs[i]) begin
      for (int b = 0; b < segs[i].nbits; b++)
        send((b % segs[i].gap == 0) && (b / segs[i].gap < segs[i].nerr), 1'b0);
      chk($sformatf("seg%0d_locked", i), bus.locked, segs[i].exp_locked);
      chk($sformatf("seg%0d_err_count", i), bus.err_count, segs[i].exp_errs);
      chk($sformatf("seg%0d_bit_count", i), bus.bit_count, segs[i].exp_bits);
    end
    send(1'b1, 1'b0);
    chk("pulse_high", bus.err_pulse, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse_one_cycle", bus.err_pulse, 0);
    repeat (5) send(1'b0, 1'b0);
    chk("single_err_count", bus.err_count, 24);
    chk("single_err_locked", bus.locked, 1);
    send(1'b1, 1'b1);
    chk("clear_wins_err", bus.err_count, 0);
    chk("clear_wins_bits", bus.bit_count, 0);
    chk("clear_keeps_lock", bus.locked, 1);
    send(1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_mid_lock_locked", bus.locked, 0);
    chk("rst_mid_lock_pulse", bus.err_pulse, 0);
    chk("rst_mid_lock_bits", bus.bit_count, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stuck_low_locked", bus.locked, 0);
    chk("stuck_low_errs", bus.err_count, 0);
    do_reset();
    rate = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 0;
          1: rate = 64;
          default: rate = 6;
        endcase
        if ($urandom_range(0, 3) == 0) gen_s = 7'($urandom_range(1, 127));
      end
      r = $urandom_range(0, 999) == 0;
      dv = $urandom_range(0, 9) < 7;
      clr = $urandom_range(0, 299) == 0;
      flip = rate != 0 && $urandom_range(0, rate - 1) == 0;
      if (dv && !r) step(gen_next() ^ flip, 1'b1, clr, 1'b0);
      else step(1'($urandom_range(0, 1)), dv, clr, r);
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 32, consecutive matching bits in HUNT before lock is declared.
REQ-002 Parameter LOSS_ERRS, default 8, errors within one window that force loss of lock.
REQ-003 Parameter WINDOW, default 64, window length in valid bits for loss-of-lock counting.
REQ-004 clk_x8  input  1  single clock (8x oversample clock); all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 d_in  input  1  received bit, sampled only when d_valid=1.
REQ-007 d_valid  input  1  one-cycle strobe per recovered bit.
REQ-008 clear_counts  input  1  synchronous clear of err_count and bit_count.
REQ-009 locked  output  1  checker is in LOCKED state.
REQ-010 err_pulse  output  1  one-cycle pulse per bit error detected while LOCKED.
REQ-011 err_count  output  16  saturating error count while LOCKED.
REQ-012 bit_count  output  32  saturating count of valid bits checked while LOCKED.

Function
REQ-013 Sequence is PRBS7, x^7+x^6+1: state s[6:0], predicted bit p = s[6]^s[5].
REQ-014 Cycles with d_valid=0 leave all state, counters and outputs unchanged, except err_pulse, which is 0.
REQ-015 States: HUNT, LOCKED; reset state HUNT.
REQ-016 HUNT, every valid bit: s <= {s[5:0], d_in} (self-synchronising load from the line).
REQ-017 HUNT: a 3-bit fill counter counts the first 7 valid bits after entry; no comparison is made until fill = 7.
REQ-018 HUNT, fill = 7: a bit is a match iff d_in == p and s != 0; a match increments the run counter, and any non-match clears it to 0.
REQ-019 The all-zero state never counts as a match, so a stuck-low line never locks.
REQ-020 HUNT -> LOCKED on the valid bit that brings run to LOCK_COUNT; locked=1 from the next cycle.
REQ-021 On LOCKED entry: window counter and window error counter are 0; err_count and bit_count are not cleared.
REQ-022 LOCKED, every valid bit: s <= {s[5:0], p} (free-running, line not fed back); bit_count += 1, saturating at 0xFFFFFFFF.
REQ-023 LOCKED: on d_in != p, err_pulse=1 for exactly the next cycle, err_count += 1 saturating at 0xFFFF, and window errors += 1.
REQ-024 The window counter runs 0..WINDOW-1 on valid bits; on the bit at WINDOW-1 it wraps to 0 and clears window errors, after including any error on that same bit.
REQ-025 Window errors reaching LOSS_ERRS: LOCKED -> HUNT next cycle, locked=0, and fill, run, window and window error counters cleared; s is kept.
REQ-026 clear_counts=1: err_count and bit_count are 0 next cycle; clear wins over a simultaneous increment; lock state, s and window counters are unaffected.
REQ-027 Loss-of-lock has priority over window wrap when both occur on the same bit.
REQ-028 Counter widths: run is $clog2(LOCK_COUNT+1) bits and window is $clog2(WINDOW) bits; no counter may wrap except the window counter.

Reset
REQ-029 While rst=1 (synchronous): state HUNT; s, fill, run, window and window error counters 0; locked=0, err_pulse=0, err_count=0, bit_count=0.
REQ-030 rst overrides clear_counts and d_valid in the same cycle; reset mid-lock drops locked on the next edge.

Verification
REQ-031 Reset, then 39 valid bits of correct PRBS7 (seed 7'h7F) -> locked=0 through the 39th bit; locked=1 the cycle after it; err_count=0.
REQ-032 Locked; invert one bit -> err_pulse high exactly 1 cycle; err_count=1; locked stays 1; subsequent correct bits give no further errors.
REQ-033 Locked; 8 inverted bits within one 64-bit window -> locked=0 the cycle after the 8th; then 39 correct bits -> relock; err_count=8.
REQ-034 Locked; 7 errors in window N and 7 in window N+1 -> locked stays 1; err_count=14.
REQ-035 d_in held 0 for 200 valid bits after reset -> locked never asserts; err_count=0.
REQ-036 clear_counts coincident with an erroneous bit -> err_count=0 next cycle; rst asserted while locked -> all outputs 0 next cycle.
